// File: rtl/bus_ctrl_ws_pkg.sv
// Shared types and helpers for the wait-state bus controller.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CNT_W    = 8;
    localparam int PACK_MAX = 1024;

    // Extract field idx of the given width from a packed per-region vector
    // (region 0 in the LSBs). Fields wider than 32 bits are not supported.
    function automatic logic [31:0] region_field(input logic [PACK_MAX-1:0] vec,
                                                 input int idx,
                                                 input int width);
        logic [PACK_MAX-1:0] sh;
        logic [31:0]         mask;
        sh   = vec >> (idx * width);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/bus_ctrl_ws_if.sv
// Bus bundle between the CPU master / peripherals and the bus controller.
interface bus_ctrl_ws_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N_REG  = 5
);
    // Handshake: the master raises i_req with stable i_addr/i_rnw/i_wdata and
    // holds it until the controller pulses o_ready for one cycle (o_err and
    // o_rdata are valid in that same cycle). Slaves see o_ce[k] (qualified by
    // o_we) and answer with i_slv_rdy[k]; the controller never completes
    // before the region's minimum wait count has elapsed.
    logic                    i_req;
    logic [ADDR_W-1:0]       i_addr;
    logic                    i_rnw;
    logic [DATA_W-1:0]       i_wdata;
    logic                    o_ready;
    logic [DATA_W-1:0]       o_rdata;
    logic                    o_err;
    logic [N_REG-1:0]        o_ce;
    logic                    o_we;
    logic [ADDR_W-1:0]       o_addr;
    logic [DATA_W-1:0]       o_wdata;
    logic [N_REG*DATA_W-1:0] i_slv_rdata;
    logic [N_REG-1:0]        i_slv_rdy;

    // Master side: the CPU plus the peripheral responders.
    modport master (
        output i_req, i_addr, i_rnw, i_wdata, i_slv_rdata, i_slv_rdy,
        input  o_ready, o_rdata, o_err, o_ce, o_we, o_addr, o_wdata
    );

    // Slave side: the bus controller itself.
    modport slave (
        input  i_req, i_addr, i_rnw, i_wdata, i_slv_rdata, i_slv_rdy,
        output o_ready, o_rdata, o_err, o_ce, o_we, o_addr, o_wdata
    );
endinterface

// File: rtl/bus_ctrl_ws_decoder.sv
// Combinational priority address decoder: lowest matching region index wins.
module bus_region_decoder
    import bus_ctrl_pkg::*;
#(
    parameter int                      ADDR_W   = 16,
    parameter int                      N_REG    = 5,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {16'h8000, 16'h6000, 16'h4000, 16'h2000, 16'h0000},
    parameter logic [N_REG*ADDR_W-1:0] REG_MASK = {16'h8000, 16'hE000, 16'hFFE0, 16'hE000, 16'hE000},
    localparam int                     IDX_W    = (N_REG > 1) ? $clog2(N_REG) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_REG-1:0]  hit_vec,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_vec = '0;
        base    = '0;
        mask    = '0;
        for (int k = 0; k < N_REG; k++) begin
            base = ADDR_W'(region_field(PACK_MAX'(REG_BASE), k, ADDR_W));
            mask = ADDR_W'(region_field(PACK_MAX'(REG_MASK), k, ADDR_W));
            if (!hit && ((addr & mask) == base)) begin
                hit        = 1'b1;
                hit_idx    = IDX_W'(k);
                hit_vec[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_ctrl_ws.sv
// Bus control unit: region decode, registered chip enables, per-region wait
// states with slave-ready handshake, timeout error and open-bus latch.
module bus_ctrl_ws
    import bus_ctrl_pkg::*;
#(
    parameter int                      ADDR_W        = 16,
    parameter int                      DATA_W        = 8,
    parameter int                      N_REG         = 5,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE      = {16'h8000, 16'h6000, 16'h4000, 16'h2000, 16'h0000},
    parameter logic [N_REG*ADDR_W-1:0] REG_MASK      = {16'h8000, 16'hE000, 16'hFFE0, 16'hE000, 16'hE000},
    parameter logic [N_REG*4-1:0]      REG_WAIT      = {4'd1, 4'd2, 4'd0, 4'd1, 4'd0},
    parameter int                      TIMEOUT       = 15,
    parameter logic [DATA_W-1:0]       OPEN_BUS_INIT = 8'hFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_ctrl_ws_if.slave  bus,
    output state_t        o_dbg_state
);

    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               rnw_q, rnw_n;
    logic [DATA_W-1:0]  open_bus, open_bus_n;
    logic [N_REG-1:0]   ce_n;
    logic               we_n, ready_n, err_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wdata_n, rdata_n;

    logic [N_REG-1:0]   hit_vec;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    logic [CNT_W-1:0]   wait_k, limit_k;
    logic [CNT_W:0]     limit_sum;
    logic [DATA_W-1:0]  slv_data_k;
    logic               rdy_k;

    bus_region_decoder #(
        .ADDR_W   (ADDR_W),
        .N_REG    (N_REG),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_dec (
        .addr    (bus.i_addr),
        .hit_vec (hit_vec),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    // Timeout limit clamps at the counter's saturation value so it stays reachable.
    always_comb begin
        wait_k     = CNT_W'(region_field(PACK_MAX'(REG_WAIT), int'(idx), 4));
        limit_sum  = {1'b0, wait_k} + (CNT_W+1)'(TIMEOUT);
        limit_k    = limit_sum[CNT_W] ? '1 : limit_sum[CNT_W-1:0];
        slv_data_k = DATA_W'(region_field(PACK_MAX'(bus.i_slv_rdata), int'(idx), DATA_W));
        rdy_k      = bus.i_slv_rdy[idx];
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        rnw_n      = rnw_q;
        open_bus_n = open_bus;
        ce_n       = bus.o_ce;
        we_n       = bus.o_we;
        addr_n     = bus.o_addr;
        wdata_n    = bus.o_wdata;
        rdata_n    = bus.o_rdata;
        ready_n    = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_req) begin
                    addr_n  = bus.i_addr;
                    wdata_n = bus.i_wdata;
                    rnw_n   = bus.i_rnw;
                    if (hit) begin
                        idx_n   = hit_idx;
                        ce_n    = hit_vec;
                        we_n    = !bus.i_rnw;
                        cnt_n   = '0;
                        state_n = ACCESS;
                    end else begin
                        // Unmapped: nobody drives the bus, the read sees open-bus.
                        ready_n = 1'b1;
                        if (bus.i_rnw) rdata_n = open_bus;
                        state_n = DONE;
                    end
                end
            end
            ACCESS: begin
                if ((cnt >= wait_k) && rdy_k) begin
                    ce_n    = '0;
                    we_n    = 1'b0;
                    ready_n = 1'b1;
                    state_n = DONE;
                    if (rnw_q) begin
                        rdata_n    = slv_data_k;
                        open_bus_n = slv_data_k;
                    end else begin
                        open_bus_n = bus.o_wdata;
                    end
                end else if (cnt >= limit_k) begin
                    ce_n    = '0;
                    we_n    = 1'b0;
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                    state_n = DONE;
                    if (rnw_q) rdata_n = open_bus;
                end else begin
                    cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            rnw_q       <= 1'b1;
            open_bus    <= OPEN_BUS_INIT;
            bus.o_ce    <= '0;
            bus.o_we    <= 1'b0;
            bus.o_addr  <= '0;
            bus.o_wdata <= '0;
            bus.o_rdata <= OPEN_BUS_INIT;
            bus.o_ready <= 1'b0;
            bus.o_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            rnw_q       <= rnw_n;
            open_bus    <= open_bus_n;
            bus.o_ce    <= ce_n;
            bus.o_we    <= we_n;
            bus.o_addr  <= addr_n;
            bus.o_wdata <= wdata_n;
            bus.o_rdata <= rdata_n;
            bus.o_ready <= ready_n;
            bus.o_err   <= err_n;
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_bus_ctrl_ws.sv
// Directed scoreboard bench for bus_ctrl_ws: expectations queued at issue,
// checked by a monitor on every o_ready pulse.
module tb_bus_ctrl_ws;
    import bus_ctrl_pkg::*;

    localparam int EW = 39;  // {ready_cycle[15:0], ce_cycles[7:0], ce[4:0], we, err, rdata[7:0]}

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    always #5 clk = ~clk;

    bus_ctrl_ws_if #(.ADDR_W(16), .DATA_W(8), .N_REG(5)) bus ();

    bus_ctrl_ws dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    logic [EW-1:0] exp_q[$];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    logic [15:0]   cyc      = '0;

    always @(posedge clk) cyc <= cyc + 16'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Slave responder: ready rises once the chip enable has been high rdy_delay cycles.
    int rdy_delay = 0;
    bit rdy_never = 1'b0;
    int age       = 0;

    always @(negedge clk) begin
        if (rst || bus.o_ce == '0) begin
            age           = 0;
            bus.i_slv_rdy = '0;
        end else begin
            bus.i_slv_rdy = (!rdy_never && age >= rdy_delay) ? 5'h1F : 5'h00;
            age++;
        end
    end

    // Monitor: accumulates chip-enable activity and scores each completion.
    int            ce_cyc  = 0;
    logic [4:0]    ce_seen = '0;
    logic          we_seen = 1'b0;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            ce_cyc  = 0;
            ce_seen = '0;
            we_seen = 1'b0;
        end else begin
            if (bus.o_ce != '0) begin
                ce_cyc++;
                ce_seen |= bus.o_ce;
                we_seen |= bus.o_we;
            end
            if (!bus.o_ready && bus.o_err) check("err_outside_ready", 32'(bus.o_err), 32'd0);
            if (bus.o_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata",       32'(bus.o_rdata), 32'(e[7:0]));
                    check("err",         32'(bus.o_err),   32'(e[8]));
                    check("we",          32'(we_seen),     32'(e[9]));
                    check("ce_vec",      32'(ce_seen),     32'(e[14:10]));
                    check("ce_cycles",   32'(ce_cyc),      32'(e[22:15]));
                    check("ready_cycle", 32'(cyc),         32'(e[38:23]));
                end
                ce_cyc  = 0;
                ce_seen = '0;
                we_seen = 1'b0;
            end
        end
    end

    // lat counts cycles from the current (IDLE) cycle to the o_ready cycle.
    task automatic expect_xfer(input int lat, input int ce_cycles, input logic [4:0] ce,
                               input logic we, input logic err, input logic [7:0] rdata);
        exp_q.push_back({16'(int'(cyc) + lat), 8'(ce_cycles), ce, we, err, rdata});
    endtask

    task automatic issue(input logic [15:0] a, input logic rnw, input logic [7:0] wd);
        bus.i_req   = 1'b1;
        bus.i_addr  = a;
        bus.i_rnw   = rnw;
        bus.i_wdata = wd;
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = bus.o_ready;
        end
        if (!seen) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string name, input logic [15:0] a, input logic rnw,
                       input logic [7:0] wd, input int lat, input int ce_cycles,
                       input logic [4:0] ce, input logic we, input logic err,
                       input logic [7:0] rdata);
        expect_xfer(lat, ce_cycles, ce, we, err, rdata);
        issue(a, rnw, wd);
        wait_ready(name);
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_req       = 1'b0;
        bus.i_addr      = '0;
        bus.i_rnw       = 1'b1;
        bus.i_wdata     = '0;
        bus.i_slv_rdata = {8'h96, 8'h77, 8'h40, 8'h21, 8'h3C};
        bus.i_slv_rdy   = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_err",   32'(bus.o_err),   32'd0);
        check("rst_ce",    32'(bus.o_ce),    32'd0);
        check("rst_we",    32'(bus.o_we),    32'd0);
        check("rst_rdata", 32'(bus.o_rdata), 32'hFF);
        check("rst_addr",  32'(bus.o_addr),  32'd0);
        check("rst_wdata", 32'(bus.o_wdata), 32'd0);
        check("rst_state", 32'(dbg_state),   32'(IDLE));

        run("rd_r0",    16'h0005, 1'b1, 8'h00, 2, 1, 5'b00001, 1'b0, 1'b0, 8'h3C);
        run("wr_r3",    16'h6010, 1'b0, 8'hA5, 4, 3, 5'b01000, 1'b1, 1'b0, 8'h3C);
        check("wr_o_wdata", 32'(bus.o_wdata), 32'hA5);
        check("wr_o_addr",  32'(bus.o_addr),  32'h6010);
        run("rd_unmap", 16'h5000, 1'b1, 8'h00, 1, 0, 5'b00000, 1'b0, 1'b0, 8'hA5);

        rdy_never = 1'b1;
        run("rd_tmo",   16'h2002, 1'b1, 8'h00, 18, 17, 5'b00010, 1'b0, 1'b1, 8'hA5);
        rdy_never = 1'b0;

        rdy_delay = 3;
        run("rd_slow",  16'h4015, 1'b1, 8'h00, 5, 4, 5'b00100, 1'b0, 1'b0, 8'h40);
        rdy_delay = 0;

        // Reset in the middle of an access: no completion may follow.
        issue(16'h8000, 1'b1, 8'h00);
        @(negedge clk);
        check("pre_rst_state", 32'(dbg_state), 32'(ACCESS));
        check("pre_rst_ce",    32'(bus.o_ce),  32'h10);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ce",    32'(bus.o_ce),    32'd0);
        check("mid_rst_rdata", 32'(bus.o_rdata), 32'hFF);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd0);
        check("mid_rst_state", 32'(dbg_state),   32'(IDLE));
        bus.i_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        run("rd_r4",    16'h8000, 1'b1, 8'h00, 3, 2, 5'b10000, 1'b0, 1'b0, 8'h96);

        // Back-to-back reads with i_req held through the first o_ready.
        expect_xfer(2, 1, 5'b00001, 1'b0, 1'b0, 8'h3C);
        issue(16'h0001, 1'b1, 8'h00);
        wait_ready("b2b_first");
        expect_xfer(4, 2, 5'b10000, 1'b0, 1'b0, 8'h96);
        issue(16'hFFFC, 1'b1, 8'h00);
        wait_ready("b2b_second");
        bus.i_req = 1'b0;
        repeat (3) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bus_ctrl_ws.md
Name: bus_ctrl_ws

Overview:
Parametrised successor bus control unit: N address regions defined by base/mask parameters, lowest-index-wins priority decode, registered chip enables. Adds per-region wait states, a slave-ready handshake, a timeout with error flag, and an open-bus latch. Sits between the CPU bus master and all memory/MMIO peripherals (RAM, PPU, APU/IO, save RAM, cartridge).

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
N_REG, 5, number of decoded regions
REG_BASE, {16'h8000,16'h6000,16'h4000,16'h2000,16'h0000}, packed N_REG*ADDR_W bases, region 0 in LSBs
REG_MASK, {16'h8000,16'hE000,16'hFFE0,16'hE000,16'hE000}, packed masks; hit when (addr & mask) == base
REG_WAIT, {4'd1,4'd2,4'd0,4'd1,4'd0}, packed N_REG*4 minimum wait cycles per region
TIMEOUT, 15, extra cycles allowed after wait expiry for slave ready (1..255)
OPEN_BUS_INIT, 8'hFF, reset value of the open-bus latch

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_req  in  1  master request, held until o_ready
i_addr  in  ADDR_W  master address
i_rnw  in  1  1=read, 0=write
i_wdata  in  DATA_W  master write data
o_ready  out  1  one-cycle transaction-complete pulse
o_rdata  out  DATA_W  registered read data
o_err  out  1  valid with o_ready; 1 = timeout
o_ce  out  N_REG  one-hot registered chip enables
o_we  out  1  write strobe, qualifies o_ce
o_addr  out  ADDR_W  latched address to slaves
o_wdata  out  DATA_W  latched write data to slaves
i_slv_rdata  in  N_REG*DATA_W  packed slave read data
i_slv_rdy  in  N_REG  per-slave ready (tie 1 if fixed latency)

Behaviour:
- Reset (async): state IDLE; o_ce=0, o_we=0, o_ready=0, o_err=0, o_rdata=OPEN_BUS_INIT, o_addr=0, o_wdata=0, counter=0, open-bus latch=OPEN_BUS_INIT. Reset mid-transaction aborts it; no o_ready is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when i_req=1, latch addr/rnw/wdata; decode the lowest-index region that hits. Hit: o_ce[k]<=1, o_we<=!rnw, cnt<=0, go ACCESS. No hit: go DONE directly with o_err=0, read data = open-bus latch; o_ce stays 0.
- ACCESS: cnt increments each cycle, saturating at 255. Completes when cnt>=REG_WAIT[k] and i_slv_rdy[k]=1. On a read, o_rdata<=i_slv_rdata[k], and the open-bus latch takes the same value. On a write, the open-bus latch<=wdata. Completion deasserts o_ce/o_we and goes to DONE with o_err=0.
- Timeout: if cnt reaches REG_WAIT[k]+TIMEOUT with no completion: drop o_ce/o_we, o_err<=1, o_rdata<=open-bus latch (read), latch unchanged, go to DONE.
- DONE: o_ready=1 for exactly one cycle with o_err valid; then IDLE. o_err clears on the next IDLE.
- Latency: a request sampled in IDLE at cycle T gives o_ready at T+2+REG_WAIT[k], slave ready permitting. Unmapped access: o_ready at T+1.
- The master must drop i_req in the o_ready cycle unless it issues a back-to-back request. i_req high in IDLE always starts a new transaction. Changes to i_addr/i_wdata during ACCESS are ignored.
- o_rdata holds its value until the next completed read. Writes do not change o_rdata.
- Overlapping regions: lower index wins. Widths: the base/mask compare is full ADDR_W; cnt is 8 bits.

Decomposition:
- Package bus_ctrl_pkg: state enum (IDLE/ACCESS/DONE), CNT_W=8 constant, and function region_field() for extracting packed slices.
- Sub-module bus_region_decoder: combinational priority decode of address to one-hot hit vector plus hit flag. The top level holds the FSM, counter and latches.

Test Plan:
- Reset then read 16'h0005 (region 0, wait 0, rdy=1, slave data 8'h3C) -> o_ce[0] for 1 cycle, o_ready at T+2, o_rdata=8'h3C, o_err=0.
- Write 16'h6010 data 8'hA5 (region 3, wait 2) -> o_ce[3]&o_we for 3 cycles, o_wdata=8'hA5, o_ready at T+4; then read unmapped 16'h5000 -> o_ready at T+1, o_rdata=8'hA5, o_ce=0.
- Read 16'h2002 with i_slv_rdy[1] held 0 -> o_ce[1] for 1+15+1 cycles, o_ready with o_err=1, o_rdata=last open-bus value.
- Read 16'h4015 with rdy low 3 cycles then high, data 8'h40 -> o_ready at T+5, o_rdata=8'h40, o_err=0.
- Assert i_reset during the ACCESS of a 16'h8000 read -> o_ce=0, no o_ready, o_rdata=8'hFF immediately; the next request completes normally.
- Back-to-back reads 16'h0001 then 16'hFFFC with i_req held -> two o_ready pulses separated by one IDLE cycle; data is correct for each read.
